// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM states, step
// counter width and the per-step operand-half / shift schedule.
package mult_pkg;

  localparam int unsigned STEP_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [STEP_W-1:0] LAST_STEP = '1;

  // Bit i set: step i takes the upper 16-bit half of that operand.
  localparam logic [3:0] A_HI_SEL = 4'b1100;
  localparam logic [3:0] B_HI_SEL = 4'b1010;

  localparam logic [5:0] SHIFT_S0 = 6'd0;
  localparam logic [5:0] SHIFT_S1 = 6'd16;
  localparam logic [5:0] SHIFT_S2 = 6'd16;
  localparam logic [5:0] SHIFT_S3 = 6'd32;

  function automatic logic [5:0] step_shift(input logic [STEP_W-1:0] s);
    case (s)
      2'd0:    return SHIFT_S0;
      2'd1:    return SHIFT_S1;
      2'd2:    return SHIFT_S2;
      default: return SHIFT_S3;
    endcase
  endfunction

endpackage

// File: rtl/mult32_seq_accum_if.sv
// Operand-issue / product-consumer handshake bundle for mult32_seq_accum.
interface mult32_seq_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/mul16_core.sv
// Combinational 16x16 -> 32 unsigned multiplier, shared across all steps.
module mul16_core (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/mult32_seq_accum.sv
// Sequential 32x32 unsigned multiplier: four 16x16 partial products on one
// core, shifted and summed into a 64-bit accumulator.
module mult32_seq_accum
  import mult_pkg::*;
#(
  parameter bit REG_PP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  mult32_seq_accum_if.slave  bus
);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [63:0]       acc_q, acc_d, acc_term;
  logic [31:0]       pp_raw, pp_q, pp_d;
  logic [5:0]        pp_shift_q, pp_shift_d, cur_shift;
  logic              pp_vld_q, pp_vld_d;
  logic [15:0]       op_a, op_b;

  mul16_core u_core (
    .a (op_a),
    .b (op_b),
    .p (pp_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      pp_q       <= '0;
      pp_shift_q <= '0;
      pp_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      pp_q       <= pp_d;
      pp_shift_q <= pp_shift_d;
      pp_vld_q   <= pp_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.in_valid) state_d = MUL;
      MUL:   if (step_q == LAST_STEP) state_d = REG_PP ? DRAIN : DONE;
      DRAIN: state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a       = A_HI_SEL[step_q] ? a_q[31:16] : a_q[15:0];
    op_b       = B_HI_SEL[step_q] ? b_q[31:16] : b_q[15:0];
    cur_shift  = step_shift(step_q);
    // Registered mode sums the product captured last cycle, with its own shift.
    if (REG_PP) acc_term = pp_vld_q ? (64'(pp_q) << pp_shift_q) : '0;
    else        acc_term = 64'(pp_raw) << cur_shift;

    a_d        = a_q;
    b_d        = b_q;
    step_d     = step_q;
    acc_d      = acc_q;
    pp_d       = pp_q;
    pp_shift_d = pp_shift_q;
    pp_vld_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.in_a;
          b_d    = bus.in_b;
          acc_d  = '0;
          step_d = '0;
        end
      end
      MUL: begin
        acc_d      = acc_q + acc_term;
        step_d     = step_q + 2'd1;
        pp_d       = pp_raw;
        pp_shift_d = cur_shift;
        pp_vld_d   = 1'b1;
      end
      DRAIN: acc_d = acc_q + acc_term;
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE) && !rst;
    bus.out_valid   = (state_q == DONE);
    bus.out_product = acc_q;
    bus.busy        = (state_q != IDLE);
  end

endmodule
